rom_load_ctrl: RTL and testbench
================================

# rom_load_ctrl

Sequencer between the byte-stream ROM loader and the shared cartridge memory port. During loading it buffers loader bytes and writes them to consecutive memory addresses while holding the console in reset. Afterwards it records ROM size and mirror mask, releases the console, and forwards CPU cartridge reads to the same memory port with address mirroring.

## Interface
Parameters:
- ADDR_W, 18: memory byte-address width (256 KB).
- FIFO_DEPTH, 4: input byte buffer depth; power of two, ≥2.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- ld_data  in  8  loader byte
- ld_valid  in  1  ld_data valid, one-cycle strobe per byte
- ld_loading  in  1  loader busy; high until the last byte is issued
- ld_fail  in  1  loader error
- cpu_rd  in  1  CPU read request, one-cycle strobe
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_rdata  out  8  read data
- cpu_ready  out  1  one-cycle strobe, cpu_rdata valid
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  8  write data
- mem_ack  in  1  one-cycle completion strobe
- mem_rdata  in  8  read data, valid with mem_ack
- sys_resetn  out  1  console reset, active-low
- rom_size  out  ADDR_W+1  bytes written
- rom_mask  out  ADDR_W  mirror mask
- load_done  out  1  load completed OK
- load_error  out  1  load failed, sticky until reset

## Operation
- States: IDLE, LOAD, DRAIN, MASK, RUN, ERROR.
- IDLE → LOAD when ld_loading=1. ld_valid in IDLE is ignored.
- LOAD:
  - Each ld_valid pushes ld_data into the FIFO.
  - When the FIFO is non-empty and no request is outstanding, the block issues a write with mem_addr=wr_ptr and data from the FIFO head.
  - On mem_ack the block pops the FIFO and increments wr_ptr.
  - ld_valid with the FIFO full, or a write at wr_ptr = 2^ADDR_W → ERROR (overflow).
- LOAD → DRAIN when ld_loading=0. A ld_valid in the same cycle is still accepted.
- DRAIN → MASK when the FIFO is empty and no request is outstanding.
- MASK (1 cycle):
  - rom_size = wr_ptr.
  - rom_mask = 2^k−1 for the smallest k with 2^k ≥ rom_size.
  - rom_size=0 → ERROR.
- RUN:
  - load_done=1; sys_resetn=1 from the cycle after entering RUN.
  - cpu_rd latches cpu_addr & rom_mask and issues a read with mem_we=0.
  - On mem_ack: cpu_rdata=mem_rdata and cpu_ready=1 for 1 cycle.
  - cpu_rd while a read is outstanding is dropped.
  - ld_valid is ignored.
- ld_fail=1 in any state except RUN → ERROR.
- ERROR: terminal until reset. sys_resetn=0, load_error=1, mem_req=0 once any outstanding request is acked.
- An outstanding request is never abandoned except by reset.

## Timing
- Reset values (all async): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, cpu_ready=0, sys_resetn=0, rom_size=0, rom_mask=0, load_done=0, load_error=0, FIFO empty, wr_ptr=0.
- All outputs are registered.
- Write issue: mem_req rises the cycle after the FIFO becomes non-empty. The next request can rise the cycle after mem_ack.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1. mem_req drops the cycle after mem_ack.
- CPU read latency: cpu_ready arrives 1 cycle after mem_ack; the minimum from cpu_rd to cpu_ready is 3 cycles at zero-wait ack.
- Simultaneous FIFO push and pop is allowed, including when full, because the pop frees the slot.
- Reset asserted mid-load or mid-read: immediate return to IDLE and mem_req=0. The memory side tolerates a dropped request.

## Structure
- Package rom_load_pkg:
  - state enum rom_load_state_t
  - mask function mask_for_size(size)
- Sub-module rom_load_fifo (ADDR-free synchronous byte FIFO with push, pop, full, empty) instantiated once.
- Everything else, including the FSM and memory mux, stays in rom_load_ctrl.

## Test plan
- Load 4 bytes (0x11, 0x22, 0x33, 0x44) at one byte per 16 cycles with zero-wait ack → memory addresses 0–3 hold these values; rom_size=4, rom_mask=0x3, load_done=1; sys_resetn rises 1 cycle after RUN.
- Load 5 bytes, then cpu_rd at addr 0x6 → mem_addr=0x6 (mask 0x7); cpu_ready returns the byte at 6.
- Load 16 bytes, then cpu_rd at addr 0x13 → mem_addr=0x3 (mirror).
- Stall mem_ack for 20 cycles while 5 ld_valid strobes arrive with FIFO_DEPTH=4 → ERROR; load_error=1, sys_resetn stays 0.
- Load 3 bytes, then ld_fail=1 → ERROR; no further mem_req after the outstanding ack.
- Assert resetn=0 while mem_req=1 mid-load → all outputs return to reset values in the same cycle. A fresh load after release starts at mem_addr=0.

Source files
------------

// File: rtl/rom_load_pkg.sv
// Shared types and helpers for the ROM load sequencer: FSM state encoding and
// the power-of-two mirror mask derived from the loaded image size.
package rom_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    MASK,
    RUN,
    ERROR
  } rom_load_state_t;

  localparam int MASK_W = 32;

  // Smallest 2^k-1 covering size-1: smear the highest set bit of (size-1) downward.
  function automatic logic [MASK_W-1:0] mask_for_size(input logic [MASK_W:0] size);
    logic [MASK_W:0] m;
    m = (size == '0) ? '0 : size - 1'b1;
    for (int i = 0; i < 5; i++) begin
      m = m | (m >> (1 << i));
    end
    return m[MASK_W-1:0];
  endfunction

endpackage

// File: rtl/rom_load_ctrl_if.sv
// Shared cartridge memory port: request held until a one-cycle ack strobe,
// read data valid with the ack.
interface rom_load_ctrl_if #(
  parameter int ADDR_W = 18
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/rom_load_fifo.sv
// Small synchronous byte FIFO with combinational head output. A push while full
// is accepted only when a pop in the same cycle frees the slot.
module rom_load_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = data_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequencer between the byte-stream ROM loader and the shared cartridge memory
// port: writes the image while holding the console in reset, then serves reads.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  input  logic              ld_loading,
  input  logic              ld_fail,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ready,
  rom_load_ctrl_if.master   mem,
  output logic              sys_resetn,
  output logic [ADDR_W:0]   rom_size,
  output logic [ADDR_W-1:0] rom_mask,
  output logic              load_done,
  output logic              load_error
);

  rom_load_state_t   state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rom_size_q, rom_size_d;
  logic [ADDR_W-1:0] rom_mask_q, rom_mask_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic              sys_resetn_q, sys_resetn_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ack;
  logic              issue_wr;

  rom_load_fifo #(
    .DATA_W(8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (fifo_push),
    .din   (ld_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ack      = mem_req_q && mem.mem_ack;
  assign issue_wr = !mem_req_q && !fifo_empty;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wr_ptr_d     = wr_ptr_q;
    rom_size_d   = rom_size_q;
    rom_mask_d   = rom_mask_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    sys_resetn_d = sys_resetn_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_ready_d  = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;

    // A request, once raised, is only ever retired by its ack (or by reset).
    if (ack) begin
      mem_req_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ld_fail) begin
          state_d = ERROR;
        end else if (ld_loading) begin
          state_d = LOAD;
        end
      end

      LOAD, DRAIN: begin
        if (ack) begin
          fifo_pop = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (state_q == LOAD) begin
          fifo_push = ld_valid;
        end
        // Overflow: byte with no free slot, or image larger than the address space.
        if (ld_fail ||
            (state_q == LOAD && ld_valid && fifo_full && !ack) ||
            (issue_wr && wr_ptr_q[ADDR_W])) begin
          state_d = ERROR;
        end else begin
          if (issue_wr) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q[ADDR_W-1:0];
            mem_wdata_d = fifo_dout;
          end
          if (state_q == LOAD) begin
            if (!ld_loading) begin
              state_d = DRAIN;
            end
          end else if (fifo_empty && !mem_req_q) begin
            state_d = MASK;
          end
        end
      end

      MASK: begin
        rom_size_d = wr_ptr_q;
        rom_mask_d = ADDR_W'(mask_for_size((MASK_W+1)'(wr_ptr_q)));
        if (ld_fail || wr_ptr_q == '0) begin
          state_d = ERROR;
        end else begin
          state_d     = RUN;
          load_done_d = 1'b1;
        end
      end

      RUN: begin
        sys_resetn_d = 1'b1;
        if (ack) begin
          cpu_rdata_d = mem.mem_rdata;
          cpu_ready_d = 1'b1;
        end
        // Reads arriving while one is outstanding are dropped.
        if (cpu_rd && !mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = cpu_addr & rom_mask_q;
        end
      end

      default: begin
        state_d = ERROR;
      end
    endcase

    if (state_d == ERROR) begin
      load_error_d = 1'b1;
      load_done_d  = 1'b0;
      sys_resetn_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_ptr_q     <= '0;
      rom_size_q   <= '0;
      rom_mask_q   <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      sys_resetn_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_ptr_q     <= wr_ptr_d;
      rom_size_q   <= rom_size_d;
      rom_mask_q   <= rom_mask_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      sys_resetn_q <= sys_resetn_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ready_q  <= cpu_ready_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_ready     = cpu_ready_q;
  assign sys_resetn    = sys_resetn_q;
  assign rom_size      = rom_size_q;
  assign rom_mask      = rom_mask_q;
  assign load_done     = load_done_q;
  assign load_error    = load_error_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl with a behavioural memory that acks one cycle
// after seeing a request, optionally stalled.
module tb_rom_load_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_loading;
  logic        ld_fail;
  logic        cpu_rd;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        sys_resetn;
  logic [18:0] rom_size;
  logic [17:0] rom_mask;
  logic        load_done;
  logic        load_error;

  int n_checks = 0;
  int n_pass   = 0;

  rom_load_ctrl_if #(.ADDR_W(18)) mem_if ();

  rom_load_ctrl #(
    .ADDR_W    (18),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_loading(ld_loading),
    .ld_fail   (ld_fail),
    .cpu_rd    (cpu_rd),
    .cpu_addr  (cpu_addr),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem       (mem_if),
    .sys_resetn(sys_resetn),
    .rom_size  (rom_size),
    .rom_mask  (rom_mask),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten location i reads back i ^ 0x5A.
  bit [7:0]    mem_model [0:1023];
  bit          written   [0:1023];
  logic        stall = 1'b0;
  int          wait_cnt = 0;
  int          req_rises = 0;
  logic        req_prev = 1'b0;
  logic [17:0] last_rd_addr = '0;

  always @(negedge clk) begin
    if (mem_if.mem_req === 1'b1 && req_prev !== 1'b1) req_rises++;
    req_prev = mem_if.mem_req;
    if (mem_if.mem_ack === 1'b1) begin
      mem_if.mem_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      mem_if.mem_ack = 1'b0;
      if (mem_if.mem_req !== 1'b1) begin
        wait_cnt = 0;
      end else if (!stall) begin
        wait_cnt++;
        if (wait_cnt > 1) begin
          mem_if.mem_ack = 1'b1;
          if (mem_if.mem_we) begin
            mem_model[mem_if.mem_addr[9:0]] = mem_if.mem_wdata;
            written[mem_if.mem_addr[9:0]]   = 1'b1;
          end else begin
            last_rd_addr = mem_if.mem_addr;
            mem_if.mem_rdata = written[mem_if.mem_addr[9:0]] ?
                               mem_model[mem_if.mem_addr[9:0]] :
                               (mem_if.mem_addr[7:0] ^ 8'h5A);
          end
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic do_reset();
    resetn = 1'b0; ld_data = '0; ld_valid = 1'b0; ld_loading = 1'b0;
    ld_fail = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; stall = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_seq(input int n, input logic [7:0] base, input logic [7:0] step,
                          input int gap, input bit keep);
    @(negedge clk);
    ld_loading = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat (gap) @(negedge clk);
      ld_data  = base + step * 8'(i);
      ld_valid = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0;
    end
    if (!keep) ld_loading = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!load_done && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'(load_done), 1);
  endtask

  task automatic cpu_read(input logic [17:0] a, output logic [7:0] d, output int lat);
    @(negedge clk);
    cpu_addr = a; cpu_rd = 1'b1; lat = 0; d = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cpu_rd = 1'b0;
      if (cpu_ready) begin
        lat = k;
        d = cpu_rdata;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    int         lat;
    int         rises_before;

    // Reset state
    resetn = 1'b0; ld_data = '0; ld_valid = 1'b0; ld_loading = 1'b0;
    ld_fail = 1'b0; cpu_rd = 1'b0; cpu_addr = '0;
    repeat (2) @(negedge clk);
    check_val("rst_mem_req",    32'(mem_if.mem_req), 0);
    check_val("rst_mem_addr",   32'(mem_if.mem_addr), 0);
    check_val("rst_sys_resetn", 32'(sys_resetn), 0);
    check_val("rst_rom_size",   32'(rom_size), 0);
    check_val("rst_rom_mask",   32'(rom_mask), 0);
    check_val("rst_load_done",  32'(load_done), 0);
    check_val("rst_load_error", 32'(load_error), 0);
    check_val("rst_cpu_ready",  32'(cpu_ready), 0);

    // 4 bytes, slow loader
    do_reset();
    load_seq(4, 8'h11, 8'h11, 16, 1'b0);
    wait_done("t1_done");
    check_val("t1_sysrst_first_run", 32'(sys_resetn), 0);
    @(negedge clk);
    check_val("t1_sysrst_after", 32'(sys_resetn), 1);
    check_val("t1_size", 32'(rom_size), 4);
    check_val("t1_mask", 32'(rom_mask), 'h3);
    check_val("t1_mem0", 32'(mem_model[0]), 'h11);
    check_val("t1_mem1", 32'(mem_model[1]), 'h22);
    check_val("t1_mem2", 32'(mem_model[2]), 'h33);
    check_val("t1_mem3", 32'(mem_model[3]), 'h44);

    // 5 bytes, read inside the mask
    do_reset();
    load_seq(5, 8'hA0, 8'h01, 4, 1'b0);
    wait_done("t2_done");
    check_val("t2_size", 32'(rom_size), 5);
    check_val("t2_mask", 32'(rom_mask), 'h7);
    cpu_read(18'h6, rd, lat);
    check_val("t2_lat",   32'(lat), 3);
    check_val("t2_raddr", 32'(last_rd_addr), 'h6);
    check_val("t2_rdata", 32'(rd), 'h5C);

    // 16 bytes, mirrored read
    do_reset();
    load_seq(16, 8'h30, 8'h01, 4, 1'b0);
    wait_done("t3_done");
    check_val("t3_size",  32'(rom_size), 16);
    check_val("t3_mask",  32'(rom_mask), 'hF);
    check_val("t3_mem15", 32'(mem_model[15]), 'h3F);
    cpu_read(18'h13, rd, lat);
    check_val("t3_raddr", 32'(last_rd_addr), 'h3);
    check_val("t3_rdata", 32'(rd), 'h33);

    // FIFO overflow under stalled memory
    do_reset();
    stall = 1'b1;
    rises_before = req_rises;
    load_seq(5, 8'h50, 8'h01, 1, 1'b1);
    repeat (9) @(negedge clk);
    check_val("t4_error",   32'(load_error), 1);
    check_val("t4_sysrst",  32'(sys_resetn), 0);
    check_val("t4_req_held", 32'(mem_if.mem_req), 1);
    stall = 1'b0;
    repeat (5) @(negedge clk);
    check_val("t4_req_drop", 32'(mem_if.mem_req), 0);
    check_val("t4_req_count", 32'(req_rises - rises_before), 1);
    check_val("t4_done",    32'(load_done), 0);

    // Loader failure with a write outstanding
    do_reset();
    load_seq(3, 8'h11, 8'h11, 4, 1'b1);
    repeat (10) @(negedge clk);
    check_val("t5_mem2", 32'(mem_model[2]), 'h33);
    stall = 1'b1;
    load_seq(1, 8'h44, 8'h00, 1, 1'b1);
    repeat (4) @(negedge clk);
    check_val("t5_req_out", 32'(mem_if.mem_req), 1);
    rises_before = req_rises;
    ld_fail = 1'b1;
    @(negedge clk);
    ld_fail = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t5_error", 32'(load_error), 1);
    stall = 1'b0;
    repeat (10) @(negedge clk);
    check_val("t5_req_drop",  32'(mem_if.mem_req), 0);
    check_val("t5_no_new_req", 32'(req_rises - rises_before), 0);

    // Reset in the middle of a write, then a fresh 1-byte load
    do_reset();
    load_seq(2, 8'h60, 8'h01, 4, 1'b1);
    repeat (10) @(negedge clk);
    stall = 1'b1;
    load_seq(1, 8'h62, 8'h00, 1, 1'b1);
    repeat (4) @(negedge clk);
    check_val("t6_req_mid",  32'(mem_if.mem_req), 1);
    check_val("t6_addr_mid", 32'(mem_if.mem_addr), 2);
    check_val("t6_data_mid", 32'(mem_if.mem_wdata), 'h62);
    resetn = 1'b0;
    ld_loading = 1'b0;
    #1;
    check_val("t6_rst_req",   32'(mem_if.mem_req), 0);
    check_val("t6_rst_addr",  32'(mem_if.mem_addr), 0);
    check_val("t6_rst_we",    32'(mem_if.mem_we), 0);
    check_val("t6_rst_wdata", 32'(mem_if.mem_wdata), 0);
    repeat (2) @(negedge clk);
    stall = 1'b0;
    resetn = 1'b1;
    load_seq(1, 8'h99, 8'h00, 4, 1'b0);
    wait_done("t6_done");
    check_val("t6_mem0", 32'(mem_model[0]), 'h99);
    check_val("t6_size", 32'(rom_size), 1);
    check_val("t6_mask", 32'(rom_mask), 0);

    // Empty image
    do_reset();
    @(negedge clk);
    ld_loading = 1'b1;
    repeat (3) @(negedge clk);
    ld_loading = 1'b0;
    repeat (10) @(negedge clk);
    check_val("t7_error", 32'(load_error), 1);
    check_val("t7_done",  32'(load_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
